rv_decode_pipe: RTL and testbench
=================================

Name: rv_decode_pipe

Overview:
- Parametrised RV64I decode/operand-fetch stage that sits between fetch and execute.
- Selects operands from register-file read data or from NUM_FWD forwarding channels (youngest first), and generates immediates.
- Interlocks on load-use hazards and holds decode behind unresolved control transfers.
- Registers the result into the EXE pipeline latch with stall, flush and bubble handling.

Parameters:
XLEN, 64, datapath width; immediates sign-extend to XLEN.
NUM_FWD, 3, number of forwarding channels; channel 0 is the youngest and has the highest priority.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  synchronous, active-high reset.
DE_V  in  1  decode instruction valid.
DE_IR  in  32  decode instruction.
DE_NPC  in  XLEN  PC+4 of the decode instruction.
RS1_DATA  in  XLEN  register-file read of DE_IR[19:15].
RS2_DATA  in  XLEN  register-file read of DE_IR[24:20].
FWD_V  in  NUM_FWD  forwarding channel i valid.
FWD_RD  in  5*NUM_FWD  destination register of channel i, bits [5i+4:5i].
FWD_DATA  in  XLEN*NUM_FWD  result of channel i.
FWD_PEND  in  NUM_FWD  channel i result not yet available (load in flight).
EXE_STALL  in  1  execute cannot accept; hold the EXE latch.
BR_RESOLVE  in  1  pulse: outstanding control transfer resolved.
FLUSH  in  1  kill the decode instruction and the EXE latch contents.
DE_STALL  out  1  combinational; fetch must hold DE_IR/DE_NPC.
EXE_V  out  1  EXE latch valid.
EXE_IR  out  32  latched instruction.
EXE_NPC  out  XLEN  latched NPC.
EXE_OP1  out  XLEN  ALU operand 1.
EXE_OP2  out  XLEN  ALU operand 2.
EXE_STD  out  XLEN  store data (forwarded rs2).
EXE_ECALL  out  1  latched instruction is ECALL (32'h00000073).

Behaviour:
- Reset:
  - All EXE_* outputs reset to 0 and the FSM resets to RUN.
  - DE_STALL follows its equation from reset state.
- Register use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by R-type (0110011, 0111011), store and branch only.
  - Register x0 never matches a forwarding channel and always reads 0.
- Forwarding:
  - For each used rs, take the lowest i with FWD_V[i] && FWD_RD[i]==rs && rs!=0.
  - If that channel's FWD_PEND[i]=1, assert hazard. Older matching channels are ignored.
  - With no match, use RSx_DATA.
- Immediates (all sign-extended to XLEN):
  - I-type: JALR, load, OP-IMM, OP-IMM-32.
  - S-type: store.
  - B-type: branch.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - Shifts: SLLI/SRLI/SRAI use zero-extended shamt[5:0]; the W forms use shamt[4:0].
- Operand selection:
  - OP1: forwarded rs1; DE_NPC-4 for AUIPC, JAL and branch; 0 for LUI.
  - OP2: forwarded rs2 for R-type; immediate otherwise.
  - EXE_STD is always the forwarded rs2.
- Control transfer: ctl = DE_V && opcode in {1100011, 1101111, 1100111}.
- FSM, RUN:
  - If DE_V && !hazard, issue. If ctl, go to BR_WAIT.
  - If hazard, go to LD_WAIT.
- FSM, LD_WAIT:
  - Re-evaluate hazard every cycle.
  - When it clears, issue and go to RUN, or to BR_WAIT if ctl.
- FSM, BR_WAIT:
  - Decode issues nothing.
  - On BR_RESOLVE, go to RUN. The decode instruction may issue in the following cycle, not in the resolve cycle.
- Issue: on the edge, load the EXE latch with EXE_V=1 and the registered values.
  - Issue occurs only when DE_V, state permits, !hazard and !EXE_STALL.
- Bubble: when nothing issues and !EXE_STALL, EXE_V<=0 and the other EXE_* fields hold.
- EXE_STALL: the whole EXE latch holds and the FSM does not advance.
  - Exception: BR_RESOLVE is still accepted in BR_WAIT.
- DE_STALL equation: EXE_STALL | hazard | (state==BR_WAIT) | (issue of ctl this cycle is stalled).
- Priority: RESET > FLUSH > EXE_STALL > normal operation.
  - FLUSH forces EXE_V<=0 and state RUN, regardless of BR_RESOLVE or EXE_STALL in the same cycle.
- Latency: one cycle from decode to EXE latch when hazard-free.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, the block adds three outputs, all XLEN wide and reset to 0, each saturating at all-ones:
  - PERF_ISSUE counts issued instructions.
  - PERF_LD_STALL counts cycles in LD_WAIT, or RUN cycles with hazard.
  - PERF_BR_STALL counts cycles in BR_WAIT.
- When undefined, these ports and registers are absent and the block behaves identically otherwise.

Test Plan:
- `addi x1,x0,-5` (32'hFFB00093), no forwarding → next cycle EXE_V=1, EXE_OP1=0, EXE_OP2=64'hFFFF_FFFF_FFFF_FFFB.
- `add x3,x1,x2` with FWD ch0 rd=1 data=7, ch2 rd=1 data=9, RS2_DATA=4 → EXE_OP1=7, EXE_OP2=4.
- `add x3,x1,x0` with ch0 rd=1 FWD_PEND=1 for 2 cycles → DE_STALL=1 for 2 cycles, EXE_V=0 for 2 cycles, then EXE_V=1 with forwarded data; `add x0,...` with a ch0 rd=0 pending match → no stall.
- `beq` issues, BR_RESOLVE after 3 cycles → DE_STALL=1 for 3 cycles plus the resolve cycle, EXE_V=0 during the wait, next instruction issues on the cycle after resolve.
- EXE_STALL held 2 cycles during issue → EXE_* unchanged; FLUSH and BR_RESOLVE in the same cycle → EXE_V=0 next cycle, state RUN.
- RESET asserted during BR_WAIT → all outputs 0 and state RUN on the next edge; ECALL issue → EXE_ECALL=1.

Source files
------------

// File: rtl/rv_decode_pipe_if.sv
// rv_decode_pipe_if: decode-side inputs, forwarding channels and EXE latch outputs of rv_decode_pipe.
// master drives decode/forwarding/control and receives the EXE latch; slave is the decode stage.
interface rv_decode_pipe_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_FWD = 3
);
    logic                      DE_V;
    logic [31:0]               DE_IR;
    logic [XLEN-1:0]           DE_NPC;
    logic [XLEN-1:0]           RS1_DATA;
    logic [XLEN-1:0]           RS2_DATA;
    logic [NUM_FWD-1:0]        FWD_V;
    logic [5*NUM_FWD-1:0]      FWD_RD;
    logic [XLEN*NUM_FWD-1:0]   FWD_DATA;
    logic [NUM_FWD-1:0]        FWD_PEND;
    logic                      EXE_STALL;
    logic                      BR_RESOLVE;
    logic                      FLUSH;
    logic                      DE_STALL;
    logic                      EXE_V;
    logic [31:0]               EXE_IR;
    logic [XLEN-1:0]           EXE_NPC;
    logic [XLEN-1:0]           EXE_OP1;
    logic [XLEN-1:0]           EXE_OP2;
    logic [XLEN-1:0]           EXE_STD;
    logic                      EXE_ECALL;

    modport master (
        output DE_V, DE_IR, DE_NPC, RS1_DATA, RS2_DATA,
               FWD_V, FWD_RD, FWD_DATA, FWD_PEND,
               EXE_STALL, BR_RESOLVE, FLUSH,
        input  DE_STALL, EXE_V, EXE_IR, EXE_NPC, EXE_OP1, EXE_OP2, EXE_STD, EXE_ECALL
    );

    modport slave (
        input  DE_V, DE_IR, DE_NPC, RS1_DATA, RS2_DATA,
               FWD_V, FWD_RD, FWD_DATA, FWD_PEND,
               EXE_STALL, BR_RESOLVE, FLUSH,
        output DE_STALL, EXE_V, EXE_IR, EXE_NPC, EXE_OP1, EXE_OP2, EXE_STD, EXE_ECALL
    );
endinterface

// File: rtl/rv_decode_pipe.sv
// rv_decode_pipe: RV64I decode/operand-fetch stage with forwarding, load-use and branch interlocks.
// Define DECODE_PERF_CNT_EN to add saturating PERF_ISSUE/PERF_LD_STALL/PERF_BR_STALL counters.
module rv_decode_pipe #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    rv_decode_pipe_if.slave bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] PERF_ISSUE,
    output logic [XLEN-1:0] PERF_LD_STALL,
    output logic [XLEN-1:0] PERF_BR_STALL
`endif
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LD_WAIT = 2'd1;
    localparam logic [1:0] ST_BR_WAIT = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [31:0]     ir;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    logic            rs1_use, rs2_use, rtype, ctl;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, op1, op2;
    logic            rs1_pend, rs2_pend, hazard, issue;

    assign ir      = bus.DE_IR;
    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign rtype   = (opcode == OPC_OP) || (opcode == OPC_OPW);
    assign rs1_use = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    assign rs2_use = rtype || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign ctl     = bus.DE_V && ((opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR));

    // Operand forwarding: iterate oldest to youngest so channel 0 wins; x0 is hard-wired to zero.
    always_comb begin
        rs1_val  = bus.RS1_DATA;
        rs2_val  = bus.RS2_DATA;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (bus.FWD_V[i] && (bus.FWD_RD[5*i +: 5] == rs1)) begin
                rs1_val  = bus.FWD_DATA[XLEN*i +: XLEN];
                rs1_pend = bus.FWD_PEND[i];
            end
            if (bus.FWD_V[i] && (bus.FWD_RD[5*i +: 5] == rs2)) begin
                rs2_val  = bus.FWD_DATA[XLEN*i +: XLEN];
                rs2_pend = bus.FWD_PEND[i];
            end
        end
        if (rs1 == 5'd0) begin
            rs1_val  = '0;
            rs1_pend = 1'b0;
        end
        if (rs2 == 5'd0) begin
            rs2_val  = '0;
            rs2_pend = 1'b0;
        end
    end

    assign hazard = bus.DE_V && ((rs1_use && rs1_pend) || (rs2_use && rs2_pend));

    // Immediate generation
    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OPIMM:  imm = (funct3 == 3'b001 || funct3 == 3'b101) ? XLEN'(ir[25:20])
                                                                    : XLEN'($signed(ir[31:20]));
            OPC_OPIMMW: imm = (funct3 == 3'b001 || funct3 == 3'b101) ? XLEN'(ir[24:20])
                                                                    : XLEN'($signed(ir[31:20]));
            OPC_JALR, OPC_LOAD: imm = XLEN'($signed(ir[31:20]));
            OPC_STORE:  imm = XLEN'($signed({ir[31:25], ir[11:7]}));
            OPC_BRANCH: imm = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            OPC_LUI, OPC_AUIPC: imm = XLEN'($signed({ir[31:12], 12'b0}));
            OPC_JAL:    imm = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            default:    imm = '0;
        endcase
    end

    always_comb begin
        op1 = rs1_val;
        if (opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_BRANCH)
            op1 = bus.DE_NPC - XLEN'(4);
        else if (opcode == OPC_LUI)
            op1 = '0;
        op2 = rtype ? rs2_val : imm;
    end

    assign issue = bus.DE_V && (state != ST_BR_WAIT) && !hazard && !bus.EXE_STALL && !bus.FLUSH;

    assign bus.DE_STALL = bus.EXE_STALL || hazard || (state == ST_BR_WAIT)
                       || (ctl && (state != ST_BR_WAIT) && !hazard && bus.EXE_STALL);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state: EXE_STALL freezes the FSM except that a resolve still releases BR_WAIT
    always_comb begin
        state_nxt = state;
        if (bus.FLUSH) begin
            state_nxt = ST_RUN;
        end else if (bus.EXE_STALL) begin
            if (state == ST_BR_WAIT && bus.BR_RESOLVE) state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_LD_WAIT: begin
                    if (hazard)         state_nxt = ST_LD_WAIT;
                    else if (ctl)       state_nxt = ST_BR_WAIT;
                    else                state_nxt = ST_RUN;
                end
                ST_BR_WAIT: if (bus.BR_RESOLVE) state_nxt = ST_RUN;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    // EXE pipeline latch: bubbles clear only the valid bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.EXE_V     <= 1'b0;
            bus.EXE_IR    <= '0;
            bus.EXE_NPC   <= '0;
            bus.EXE_OP1   <= '0;
            bus.EXE_OP2   <= '0;
            bus.EXE_STD   <= '0;
            bus.EXE_ECALL <= 1'b0;
        end else if (bus.FLUSH) begin
            bus.EXE_V <= 1'b0;
        end else if (!bus.EXE_STALL) begin
            bus.EXE_V <= issue;
            if (issue) begin
                bus.EXE_IR    <= ir;
                bus.EXE_NPC   <= bus.DE_NPC;
                bus.EXE_OP1   <= op1;
                bus.EXE_OP2   <= op2;
                bus.EXE_STD   <= rs2_val;
                bus.EXE_ECALL <= (ir == 32'h0000_0073);
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PERF_ISSUE    <= '0;
            PERF_LD_STALL <= '0;
            PERF_BR_STALL <= '0;
        end else begin
            if (issue && !(&PERF_ISSUE))
                PERF_ISSUE <= PERF_ISSUE + XLEN'(1);
            if ((state == ST_LD_WAIT || (state == ST_RUN && hazard)) && !(&PERF_LD_STALL))
                PERF_LD_STALL <= PERF_LD_STALL + XLEN'(1);
            if (state == ST_BR_WAIT && !(&PERF_BR_STALL))
                PERF_BR_STALL <= PERF_BR_STALL + XLEN'(1);
        end
    end
`endif
endmodule

// File: tb/tb_rv_decode_pipe.sv
// tb_rv_decode_pipe: directed vectors for rv_decode_pipe with hand-computed expectations.
module tb_rv_decode_pipe;
    logic CLK;
    logic RESET;
    int   n_vec;
    int   n_err;

    rv_decode_pipe_if #(.XLEN(64), .NUM_FWD(3)) bus ();

    rv_decode_pipe #(.XLEN(64), .NUM_FWD(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_fwd();
        bus.FWD_V    = '0;
        bus.FWD_RD   = '0;
        bus.FWD_DATA = '0;
        bus.FWD_PEND = '0;
    endtask

    task automatic set_fwd(input int ch, input logic [4:0] rd, input logic [63:0] d, input logic p);
        bus.FWD_V[ch]          = 1'b1;
        bus.FWD_RD[5*ch +: 5]  = rd;
        bus.FWD_DATA[64*ch +: 64] = d;
        bus.FWD_PEND[ch]       = p;
    endtask

    task automatic present(input logic [31:0] ir, input logic [63:0] npc,
                           input logic [63:0] r1, input logic [63:0] r2);
        bus.DE_V     = 1'b1;
        bus.DE_IR    = ir;
        bus.DE_NPC   = npc;
        bus.RS1_DATA = r1;
        bus.RS2_DATA = r2;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk({tag, ".de_stall"}, 64'(bus.DE_STALL), 64'(exp));
    endtask

    task automatic chk_exe(input string tag, input logic v, input logic [31:0] ir,
                           input logic [63:0] npc, input logic [63:0] op1, input logic [63:0] op2);
        chk({tag, ".v"},   64'(bus.EXE_V), 64'(v));
        chk({tag, ".ir"},  64'(bus.EXE_IR), 64'(ir));
        chk({tag, ".npc"}, bus.EXE_NPC, npc);
        chk({tag, ".op1"}, bus.EXE_OP1, op1);
        chk({tag, ".op2"}, bus.EXE_OP2, op2);
    endtask

    initial begin
        CLK = 1'b0;
        n_vec = 0;
        n_err = 0;
        RESET = 1'b1;
        bus.DE_V = 1'b0; bus.DE_IR = '0; bus.DE_NPC = '0;
        bus.RS1_DATA = '0; bus.RS2_DATA = '0;
        bus.EXE_STALL = 1'b0; bus.BR_RESOLVE = 1'b0; bus.FLUSH = 1'b0;
        clr_fwd();
        tick(); tick();
        chk_exe("reset", 1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        chk("reset.std", bus.EXE_STD, 64'h0);
        chk("reset.ecall", 64'(bus.EXE_ECALL), 64'h0);
        RESET = 1'b0;
        chk_stall("reset", 1'b0);

        // addi x1,x0,-5
        present(32'hFFB0_0093, 64'h104, 64'h1234, 64'h0);
        chk_stall("addi", 1'b0);
        tick();
        chk_exe("addi", 1'b1, 32'hFFB0_0093, 64'h104, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB);

        // add x3,x1,x2: ch0 beats older ch1 (pending) and ch2
        present(32'h0020_81B3, 64'h108, 64'h1111, 64'h4);
        set_fwd(0, 5'd1, 64'd7, 1'b0);
        set_fwd(1, 5'd1, 64'd8, 1'b1);
        set_fwd(2, 5'd1, 64'd9, 1'b0);
        chk_stall("add_fwd", 1'b0);
        tick();
        chk_exe("add_fwd", 1'b1, 32'h0020_81B3, 64'h108, 64'd7, 64'd4);
        chk("add_fwd.std", bus.EXE_STD, 64'd4);

        // add x3,x1,x0 with load-use on ch0 for two cycles
        clr_fwd();
        present(32'h0000_81B3, 64'h10C, 64'h1111, 64'h99);
        set_fwd(0, 5'd1, 64'h55, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk_stall("ld_use", 1'b1);
            tick();
            chk("ld_use.v", 64'(bus.EXE_V), 64'h0);
            chk("ld_use.ir_hold", 64'(bus.EXE_IR), 64'h0020_81B3);
        end
        bus.FWD_PEND[0] = 1'b0;
        chk_stall("ld_use_clr", 1'b0);
        tick();
        chk_exe("ld_use_clr", 1'b1, 32'h0000_81B3, 64'h10C, 64'h55, 64'h0);
        chk("ld_use_clr.std", bus.EXE_STD, 64'h0);

        // add x0,x0,x0 with pending ch0 rd=0: x0 never matches
        clr_fwd();
        present(32'h0000_0033, 64'h110, 64'h77, 64'h88);
        set_fwd(0, 5'd0, 64'h66, 1'b1);
        chk_stall("x0", 1'b0);
        tick();
        chk_exe("x0", 1'b1, 32'h0000_0033, 64'h110, 64'h0, 64'h0);

        // srai x1,x2,63: zero-extended 6-bit shamt
        clr_fwd();
        present(32'h43F1_5093, 64'h114, 64'h8000_0000_0000_0000, 64'h0);
        tick();
        chk_exe("srai", 1'b1, 32'h43F1_5093, 64'h114, 64'h8000_0000_0000_0000, 64'd63);

        // sd x2,-8(x1): store data forwarded from ch1
        present(32'hFE20_BC23, 64'h118, 64'h2000, 64'h1);
        set_fwd(1, 5'd2, 64'hABCD, 1'b0);
        tick();
        chk_exe("sd", 1'b1, 32'hFE20_BC23, 64'h118, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd.std", bus.EXE_STD, 64'hABCD);

        // auipc x3,0x80000: negative U-immediate, OP1 = PC
        clr_fwd();
        present(32'h8000_0197, 64'h2004, 64'h5, 64'h0);
        tick();
        chk_exe("auipc", 1'b1, 32'h8000_0197, 64'h2004, 64'h2000, 64'hFFFF_FFFF_8000_0000);

        // beq x1,x2,+8 then resolve after three wait cycles
        present(32'h0020_8463, 64'h1004, 64'h11, 64'h22);
        chk_stall("beq", 1'b0);
        tick();
        chk_exe("beq", 1'b1, 32'h0020_8463, 64'h1004, 64'h1000, 64'h8);
        chk("beq.std", bus.EXE_STD, 64'h22);
        present(32'h0010_0293, 64'h1008, 64'h0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            chk_stall("br_wait", 1'b1);
            tick();
            chk("br_wait.v", 64'(bus.EXE_V), 64'h0);
        end
        bus.BR_RESOLVE = 1'b1;
        chk_stall("br_resolve", 1'b1);
        tick();
        chk("br_resolve.v", 64'(bus.EXE_V), 64'h0);
        bus.BR_RESOLVE = 1'b0;
        chk_stall("after_br", 1'b0);
        tick();
        chk_exe("after_br", 1'b1, 32'h0010_0293, 64'h1008, 64'h0, 64'h1);

        // EXE_STALL for two cycles holds the whole latch
        present(32'h1234_5137, 64'h300C, 64'h0, 64'h0);
        bus.EXE_STALL = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk_stall("exe_stall", 1'b1);
            tick();
            chk_exe("exe_stall", 1'b1, 32'h0010_0293, 64'h1008, 64'h0, 64'h1);
        end
        bus.EXE_STALL = 1'b0;
        chk_stall("lui", 1'b0);
        tick();
        chk_exe("lui", 1'b1, 32'h1234_5137, 64'h300C, 64'h0, 64'h1234_5000);

        // jal x1,-4 then FLUSH + BR_RESOLVE + EXE_STALL together
        present(32'hFFDF_F0EF, 64'h4004, 64'h0, 64'h0);
        tick();
        chk_exe("jal", 1'b1, 32'hFFDF_F0EF, 64'h4004, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFC);
        present(32'h0010_0293, 64'h4008, 64'h0, 64'h0);
        bus.FLUSH = 1'b1; bus.BR_RESOLVE = 1'b1; bus.EXE_STALL = 1'b1;
        tick();
        chk("flush.v", 64'(bus.EXE_V), 64'h0);
        bus.FLUSH = 1'b0; bus.BR_RESOLVE = 1'b0; bus.EXE_STALL = 1'b0;
        chk_stall("after_flush", 1'b0);
        tick();
        chk_exe("after_flush", 1'b1, 32'h0010_0293, 64'h4008, 64'h0, 64'h1);

        // ECALL flag
        present(32'h0000_0073, 64'h5004, 64'h0, 64'h0);
        tick();
        chk("ecall", 64'(bus.EXE_ECALL), 64'h1);

        // RESET while in BR_WAIT
        present(32'h0020_8463, 64'h6000, 64'h11, 64'h22);
        tick();
        chk("beq2.ecall", 64'(bus.EXE_ECALL), 64'h0);
        chk_stall("beq2_wait", 1'b1);
        RESET = 1'b1;
        tick();
        chk_exe("rst_br", 1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        chk("rst_br.std", bus.EXE_STD, 64'h0);
        RESET = 1'b0;
        present(32'hFFB0_0093, 64'h6004, 64'h0, 64'h0);
        chk_stall("rst_run", 1'b0);
        tick();
        chk_exe("rst_run", 1'b1, 32'hFFB0_0093, 64'h6004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
